// File: rtl/imul_share_arbiter_pkg.sv
// Shared types and constants for the shared-multiplier arbiter.
// Feature macro used by the top: IMUL_SHARE_ARBITER_STATS_EN (per-requester grant counters).
package imul_share_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int REQ_MSG_NBITS  = 64;
  localparam int RESP_MSG_NBITS = 32;
  localparam int STAT_NBITS     = 16;

  // Index width that stays at least one bit wide, so a single requester still gets a legal vector.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/imul_rr_arb.sv
// Combinational round-robin priority encoder: scans i_val starting at i_prio_ptr,
// wrapping modulo NREQ, and returns the first valid index.
module imul_rr_arb
  import imul_share_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int PTR_W = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0]  i_val,
  input  logic [PTR_W-1:0] i_prio_ptr,
  output logic [PTR_W-1:0] o_grant,
  output logic             o_any_val
);

  logic [PTR_W-1:0] w_idx [NREQ];

  // w_idx[k] is the requester examined k-th, i.e. (prio_ptr + k) mod NREQ.
  for (genvar k = 0; k < NREQ; k++) begin : g_idx
    logic [PTR_W:0] w_sum;
    assign w_sum    = {1'b0, i_prio_ptr} + (PTR_W + 1)'(k);
    assign w_idx[k] = (w_sum >= (PTR_W + 1)'(NREQ)) ? PTR_W'(w_sum - (PTR_W + 1)'(NREQ))
                                                    : PTR_W'(w_sum);
  end

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    o_grant   = '0;
    o_any_val = 1'b0;
    // Walk from the lowest priority upward; the last hit is the highest-priority requester.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_val[w_idx[k]]) begin
        o_grant   = w_idx[k];
        o_any_val = 1'b1;
      end
    end
  end

endmodule

// File: rtl/imul_share_arbiter.sv
// Shares one iterative multiplier among NREQ val/rdy requesters, one transaction in flight.
// Define IMUL_SHARE_ARBITER_STATS_EN to add per-requester saturating grant counters (grant_count).
module imul_share_arbiter
  import imul_share_arbiter_pkg::*;
#(
  parameter  int NREQ  = 2,
  localparam int PTR_W = ptr_width(NREQ)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NREQ-1:0]                 in_req_val,
  output logic [NREQ-1:0]                 in_req_rdy,
  input  logic [NREQ*REQ_MSG_NBITS-1:0]   in_req_msg,
  output logic [NREQ-1:0]                 out_resp_val,
  input  logic [NREQ-1:0]                 out_resp_rdy,
  output logic [RESP_MSG_NBITS-1:0]       out_resp_msg,
  output logic                            mul_req_val,
  input  logic                            mul_req_rdy,
  output logic [REQ_MSG_NBITS-1:0]        mul_req_msg,
  input  logic                            mul_resp_val,
  output logic                            mul_resp_rdy,
  input  logic [RESP_MSG_NBITS-1:0]       mul_resp_msg,
`ifdef IMUL_SHARE_ARBITER_STATS_EN
  output logic [NREQ*STAT_NBITS-1:0]      grant_count,
`endif
  output logic                            busy
);

  state_e           r_state;
  logic [PTR_W-1:0] r_prio_ptr;
  logic [PTR_W-1:0] r_owner;
  logic [PTR_W-1:0] w_grant;
  logic [PTR_W-1:0] w_next_ptr;
  logic             w_any_val;
  logic             w_req_go;
  logic             w_resp_go;

  imul_rr_arb #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_val      (in_req_val),
    .i_prio_ptr (r_prio_ptr),
    .o_grant    (w_grant),
    .o_any_val  (w_any_val)
  );

  assign w_req_go   = mul_req_val && mul_req_rdy;
  assign w_resp_go  = mul_resp_val && mul_resp_rdy;
  assign w_next_ptr = (r_owner == PTR_W'(NREQ - 1)) ? '0 : r_owner + PTR_W'(1);

  // Request and response paths are pure forwarding; only the handshakes depend on state.
  assign mul_req_msg  = in_req_msg[int'(w_grant)*REQ_MSG_NBITS +: REQ_MSG_NBITS];
  assign out_resp_msg = mul_resp_msg;
  assign busy         = (r_state == WAIT);

  always_comb begin
    in_req_rdy   = '0;
    out_resp_val = '0;
    mul_req_val  = 1'b0;
    mul_resp_rdy = 1'b0;
    case (r_state)
      IDLE: begin
        mul_req_val         = w_any_val;
        in_req_rdy[w_grant] = mul_req_rdy && w_any_val;
      end
      WAIT: begin
        out_resp_val[r_owner] = mul_resp_val;
        mul_resp_rdy          = out_resp_rdy[r_owner];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking <= so every register samples pre-edge values.
    if (reset) begin
      r_state    <= IDLE;
      r_prio_ptr <= '0;
      r_owner    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_req_go) begin
          r_owner <= w_grant;
          r_state <= WAIT;
        end
        WAIT: if (w_resp_go) begin
          r_prio_ptr <= w_next_ptr;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef IMUL_SHARE_ARBITER_STATS_EN
  logic [STAT_NBITS-1:0] r_grant_cnt [NREQ];

  always_ff @(posedge clk) begin
    // NOTE: this is a small flop array, not a RAM, so each entry is cleared on reset.
    if (reset) begin
      for (int i = 0; i < NREQ; i++) r_grant_cnt[i] <= '0;
    end else if (w_req_go && (r_grant_cnt[w_grant] != '1)) begin
      r_grant_cnt[w_grant] <= r_grant_cnt[w_grant] + STAT_NBITS'(1);
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    assign grant_count[i*STAT_NBITS +: STAT_NBITS] = r_grant_cnt[i];
  end
`endif

  // A response while no transaction is outstanding is a multiplier protocol error.
  a_no_resp_in_idle: assert property (@(posedge clk) disable iff (reset)
    !((r_state == IDLE) && mul_resp_val));

endmodule

// File: tb/tb_imul_share_arbiter.sv
// Directed bench for imul_share_arbiter with a behavioural iterative-multiplier model.
// Grant-counter checks are built only when IMUL_SHARE_ARBITER_STATS_EN is defined.
module tb_imul_share_arbiter;
  import imul_share_arbiter_pkg::*;

  localparam int NREQ = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       in_req_val, in_req_rdy, out_resp_val, out_resp_rdy;
  logic [NREQ*64-1:0]    in_req_msg;
  logic [31:0]           out_resp_msg, mul_resp_msg;
  logic                  mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy, busy;
  logic [63:0]           mul_req_msg;
`ifdef IMUL_SHARE_ARBITER_STATS_EN
  logic [NREQ*16-1:0]    grant_count;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        m_rdy_en, m_busy;
  int          m_lat, m_cnt;
  logic [31:0] m_prod;
  logic        f_req, f_resp, f_rst;
  logic [63:0] f_msg;
  logic        flag_ok;
  int          n;

  imul_share_arbiter #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_req_val   (in_req_val),
    .in_req_rdy   (in_req_rdy),
    .in_req_msg   (in_req_msg),
    .out_resp_val (out_resp_val),
    .out_resp_rdy (out_resp_rdy),
    .out_resp_msg (out_resp_msg),
    .mul_req_val  (mul_req_val),
    .mul_req_rdy  (mul_req_rdy),
    .mul_req_msg  (mul_req_msg),
    .mul_resp_val (mul_resp_val),
    .mul_resp_rdy (mul_resp_rdy),
    .mul_resp_msg (mul_resp_msg),
`ifdef IMUL_SHARE_ARBITER_STATS_EN
    .grant_count  (grant_count),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  assign mul_req_rdy = m_rdy_en && !m_busy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives and checks happen 2 ns after the falling edge; the model samples at +4 ns.
  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input int idx, input int budget);
    int k;
    k = 0;
    while (!out_resp_val[idx] && k < budget) begin
      cyc();
      k++;
    end
    check({tag, "_timeout"}, 64'(k < budget), 64'd1);
  endtask

  // Expects requester idx to be granted now, then its product to come back on its port.
  task automatic xact(input string tag, input int idx, input logic [31:0] prod);
    #1;
    check({tag, "_grant"}, 64'(in_req_rdy), 64'd1 << idx);
    cyc();
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_resp(tag, idx, 60);
    check({tag, "_prod"}, 64'(out_resp_msg), 64'(prod));
    check({tag, "_route"}, 64'(out_resp_val), 64'd1 << idx);
    cyc();
  endtask

  // Iterative multiplier: m_lat cycles after accept, holds its response until taken.
  initial begin
    m_busy       = 1'b0;
    m_cnt        = 0;
    m_prod       = '0;
    mul_resp_val = 1'b0;
    mul_resp_msg = '0;
    forever begin
      @(negedge clk);
      #4;
      f_rst  = reset;
      f_req  = mul_req_val && mul_req_rdy;
      f_resp = mul_resp_val && mul_resp_rdy;
      f_msg  = mul_req_msg;
      @(posedge clk);
      #1;
      if (f_rst) begin
        m_busy       = 1'b0;
        mul_resp_val = 1'b0;
      end else begin
        if (f_resp) begin
          m_busy       = 1'b0;
          mul_resp_val = 1'b0;
        end
        if (f_req) begin
          m_busy = 1'b1;
          m_cnt  = m_lat;
          m_prod = f_msg[63:32] * f_msg[31:0];
        end
        if (m_busy && !mul_resp_val) begin
          if (m_cnt == 0) begin
            mul_resp_val = 1'b1;
            mul_resp_msg = m_prod;
          end else begin
            m_cnt--;
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    in_req_val   = '0;
    in_req_msg   = '0;
    out_resp_rdy = '1;
    m_rdy_en     = 1'b1;
    m_lat        = 34;
    cyc();
    cyc();
    check("rst_in_req_rdy", 64'(in_req_rdy), 64'd0);
    check("rst_out_resp_val", 64'(out_resp_val), 64'd0);
    check("rst_mul_req_val", 64'(mul_req_val), 64'd0);
    check("rst_mul_resp_rdy", 64'(mul_resp_rdy), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_prio_ptr", 64'(dut.r_prio_ptr), 64'd0);
    reset = 1'b0;
    cyc();

    // Single request from requester 0, long multiplier latency.
    in_req_val        = 2'b01;
    in_req_msg[63:0]  = {32'd3, 32'd4};
    #1;
    check("t1_in_req_rdy", 64'(in_req_rdy), 64'd1);
    check("t1_mul_req_val", 64'(mul_req_val), 64'd1);
    check("t1_mul_req_msg", mul_req_msg, {32'd3, 32'd4});
    cyc();
    in_req_val = '0;
    #1;
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_no_req_rdy", 64'(in_req_rdy), 64'd0);
    check("t1_no_mul_req", 64'(mul_req_val), 64'd0);
    flag_ok = 1'b1;
    n = 0;
    while (!out_resp_val[0] && n < 60) begin
      flag_ok = flag_ok & busy;
      cyc();
      n++;
    end
    check("t1_timeout", 64'(n < 60), 64'd1);
    check("t1_busy_hold", 64'(flag_ok), 64'd1);
    check("t1_prod", 64'(out_resp_msg), 64'd12);
    check("t1_route", 64'(out_resp_val), 64'd1);
    check("t1_mul_resp_rdy", 64'(mul_resp_rdy), 64'd1);
    cyc();
    check("t1_idle_busy", 64'(busy), 64'd0);
    check("t1_idle_resp", 64'(out_resp_val), 64'd0);

    // Both requesters held valid: grants alternate 0,1,0,1.
    do_reset();
    m_lat              = 3;
    in_req_val         = 2'b11;
    in_req_msg[63:0]   = {32'd5, 32'd6};
    in_req_msg[127:64] = {32'd7, 32'd8};
    xact("t2a", 0, 32'd30);
    in_req_msg[63:0]   = {32'd2, 32'd3};
    xact("t2b", 1, 32'd56);
    in_req_msg[127:64] = {32'd4, 32'd5};
    xact("t2c", 0, 32'd6);
    xact("t2d", 1, 32'd20);
    in_req_val = '0;
    cyc();

    // Owner 1 backpressures its response for 10 cycles while requester 0 waits.
    in_req_val         = 2'b10;
    in_req_msg[127:64] = {32'd6, 32'd7};
    #1;
    check("t3_grant1", 64'(in_req_rdy), 64'd2);
    cyc();
    in_req_val       = 2'b11;
    in_req_msg[63:0] = {32'd3, 32'd5};
    out_resp_rdy     = 2'b01;
    #1;
    flag_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      flag_ok = flag_ok & !mul_resp_rdy & (in_req_rdy == 2'b00) & busy;
      cyc();
    end
    check("t3_hold", 64'(flag_ok), 64'd1);
    check("t3_resp_held", 64'(out_resp_val), 64'd2);
    out_resp_rdy = 2'b11;
    #1;
    check("t3_mul_resp_rdy", 64'(mul_resp_rdy), 64'd1);
    check("t3_prod", 64'(out_resp_msg), 64'd42);
    cyc();
    in_req_val = 2'b01;
    xact("t3r", 0, 32'd15);
    in_req_val = '0;
    cyc();

    // Reset in the middle of a transaction discards it and restores priority 0.
    m_lat              = 34;
    in_req_val         = 2'b10;
    in_req_msg[127:64] = {32'hFFFF_FFFF, 32'd2};
    #1;
    check("t4_grant1", 64'(in_req_rdy), 64'd2);
    cyc();
    in_req_val = '0;
    repeat (4) cyc();
    check("t4_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    cyc();
    check("t4_rst_busy", 64'(busy), 64'd0);
    check("t4_rst_mul_resp_rdy", 64'(mul_resp_rdy), 64'd0);
    check("t4_rst_out_resp_val", 64'(out_resp_val), 64'd0);
    check("t4_rst_mul_req_val", 64'(mul_req_val), 64'd0);
    check("t4_rst_prio_ptr", 64'(dut.r_prio_ptr), 64'd0);
    reset = 1'b0;
    m_lat = 3;
    flag_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      flag_ok = flag_ok & (out_resp_val == 2'b00) & !busy;
      cyc();
    end
    check("t4_no_stale", 64'(flag_ok), 64'd1);
    in_req_val         = 2'b11;
    in_req_msg[63:0]   = {32'd9, 32'd9};
    in_req_msg[127:64] = {32'd9, 32'd9};
    xact("t4n", 0, 32'd81);
    in_req_val = '0;
    cyc();

    // Multiplier stalls mul_req_rdy: nothing accepted, priority unchanged, grant re-evaluates.
    m_rdy_en           = 1'b0;
    in_req_val         = 2'b10;
    in_req_msg[63:0]   = {32'd2, 32'd2};
    in_req_msg[127:64] = {32'd11, 32'd3};
    #1;
    check("t5_req_msg1", mul_req_msg, {32'd11, 32'd3});
    flag_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flag_ok = flag_ok & (in_req_rdy == 2'b00) & mul_req_val & !busy;
      cyc();
    end
    check("t5_stall", 64'(flag_ok), 64'd1);
    check("t5_prio_ptr", 64'(dut.r_prio_ptr), 64'd1);
    in_req_val = 2'b01;
    #1;
    check("t5_regrant_msg", mul_req_msg, {32'd2, 32'd2});
    check("t5_regrant_rdy", 64'(in_req_rdy), 64'd0);
    cyc();
    in_req_val = 2'b10;
    m_rdy_en   = 1'b1;
    xact("t5", 1, 32'd33);
    in_req_val = '0;
    cyc();

`ifdef IMUL_SHARE_ARBITER_STATS_EN
    // Saturate requester 0's counter; requester 1 gets an exact small count.
    do_reset();
    m_lat            = 0;
    in_req_msg[63:0] = {32'd1, 32'd1};
    flag_ok          = 1'b1;
    in_req_val       = 2'b01;
    for (int g = 0; g < 65600; g++) begin
      n = 0;
      while (!out_resp_val[0] && n < 8) begin
        cyc();
        n++;
      end
      flag_ok = flag_ok & (n < 8);
      cyc();
    end
    in_req_val = 2'b10;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (!out_resp_val[1] && n < 8) begin
        cyc();
        n++;
      end
      flag_ok = flag_ok & (n < 8);
      cyc();
    end
    in_req_val = '0;
    cyc();
    check("t6_progress", 64'(flag_ok), 64'd1);
    check("t6_cnt0_sat", 64'(grant_count[15:0]), 64'hFFFF);
    check("t6_cnt1", 64'(grant_count[31:16]), 64'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
